// File: rtl/register_access_master_pkg.sv
// Shared definitions for the UDP ASCII register-access protocol (master and responder).
// Frame: ':' '0'+reg 'W'|'R' [4 data bytes, MSB first, writes only].
package register_access_master_pkg;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_W     = 8'h57;
    localparam logic [7:0] ASCII_R     = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_RX,
        S_DRAIN,
        S_RSP
    } state_e;

    function automatic logic [2:0] frame_last_idx(input logic wr);
        return wr ? 3'd6 : 3'd2;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic        wr,
                                              input logic [7:0]  reg_char,
                                              input logic [31:0] wdata);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ASCII_COLON;
            3'd1:    b = reg_char;
            3'd2:    b = wr ? ASCII_W : ASCII_R;
            3'd3:    b = wdata[31:24];
            3'd4:    b = wdata[23:16];
            3'd5:    b = wdata[15:8];
            default: b = wdata[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/register_access_master.sv
// Host-side register-access initiator: serialises one read/write request onto UDP TX
// and collects the 4-byte read response from UDP RX. `define RSP_TIMEOUT_EN adds a read timeout.
module register_access_master
    import register_access_master_pkg::*;
#(
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_write,
    input  logic [REG_ADDR_WIDTH-1:0] i_req_reg,
    input  logic [REG_WIDTH-1:0]      i_req_wdata,
    output logic                      o_rsp_valid,
    output logic [REG_WIDTH-1:0]      o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic [7:0]                o_tx_udp_payload_axis_tdata,
    output logic                      o_tx_udp_payload_axis_tvalid,
    output logic                      o_tx_udp_payload_axis_tlast,
    input  logic                      i_tx_udp_payload_axis_tready,
    input  logic [7:0]                i_rx_udp_payload_axis_tdata,
    input  logic                      i_rx_udp_payload_axis_tvalid,
    input  logic                      i_rx_udp_payload_axis_tlast,
    output logic                      o_rx_udp_payload_axis_tready
);

    if (REG_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("register_access_master: unsupported REG_WIDTH or TIMEOUT_CYCLES");
    end

    state_e                 state_q, state_d;
    logic                   wr_q, wr_d;
    logic [7:0]             reg_char_q, reg_char_d;
    logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
    logic [2:0]             tx_cnt_q, tx_cnt_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_last_q, tx_last_d;
    logic [1:0]             rx_cnt_q, rx_cnt_d;
    logic [REG_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [2:0]             tx_nxt;
    logic                   rx_hs;
`ifdef RSP_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]            to_cnt_q, to_cnt_d;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            wr_q       <= 1'b0;
            reg_char_q <= '0;
            wdata_q    <= '0;
            tx_cnt_q   <= '0;
            tx_data_q  <= '0;
            tx_last_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
`ifdef RSP_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            reg_char_q <= reg_char_d;
            wdata_q    <= wdata_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
            rx_cnt_q   <= rx_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
`ifdef RSP_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign rx_hs = i_rx_udp_payload_axis_tvalid && o_rx_udp_payload_axis_tready;

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        reg_char_d = reg_char_q;
        wdata_d    = wdata_q;
        tx_cnt_d   = tx_cnt_q;
        tx_data_d  = tx_data_q;
        tx_last_d  = tx_last_q;
        rx_cnt_d   = rx_cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tx_nxt     = tx_cnt_q + 3'd1;
`ifdef RSP_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    wr_d       = i_req_write;
                    reg_char_d = ASCII_ZERO + 8'(i_req_reg);
                    wdata_d    = i_req_wdata;
                    tx_cnt_d   = '0;
                    tx_data_d  = ASCII_COLON;
                    tx_last_d  = 1'b0;
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    state_d    = S_TX;
                end
            end
            S_TX: begin
                // tdata/tlast are preloaded one byte ahead so they hold across stalls.
                if (i_tx_udp_payload_axis_tready) begin
                    if (tx_last_q) begin
                        rx_cnt_d = '0;
`ifdef RSP_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                        state_d  = wr_q ? S_RSP : S_RX;
                    end else begin
                        tx_cnt_d  = tx_nxt;
                        tx_data_d = frame_byte(tx_nxt, wr_q, reg_char_q, wdata_q);
                        tx_last_d = (tx_nxt == frame_last_idx(wr_q));
                    end
                end
            end
            S_RX: begin
                if (rx_hs) begin
                    rdata_d = {rdata_q[REG_WIDTH-9:0], i_rx_udp_payload_axis_tdata};
`ifdef RSP_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    if (rx_cnt_q == 2'd3) begin
                        err_d   = !i_rx_udp_payload_axis_tlast;
                        state_d = i_rx_udp_payload_axis_tlast ? S_RSP : S_DRAIN;
                    end else if (i_rx_udp_payload_axis_tlast) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 2'd1;
                    end
                end
`ifdef RSP_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RSP;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
`endif
            end
            S_DRAIN: begin
                if (rx_hs && i_rx_udp_payload_axis_tlast) state_d = S_RSP;
            end
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready                  = (state_q == S_IDLE);
        o_tx_udp_payload_axis_tvalid = (state_q == S_TX);
        o_tx_udp_payload_axis_tdata  = tx_data_q;
        o_tx_udp_payload_axis_tlast  = tx_last_q;
        o_rx_udp_payload_axis_tready = (state_q != S_RSP);
        o_rsp_valid                  = (state_q == S_RSP);
        o_rsp_rdata                  = (state_q == S_RSP) ? rdata_q : '0;
        o_rsp_err                    = (state_q == S_RSP) && err_q;
    end

endmodule

// File: tb/tb_register_access_master.sv
// Self-checking bench for register_access_master: directed and randomized transactions
// compared against a frame/response model; covers RSP_TIMEOUT_EN when that macro is defined.
module tb_register_access_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_reg;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid, tx_tlast, tx_tready;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid, rx_tlast, rx_tready;

    register_access_master #(
        .REG_WIDTH(32),
        .REG_ADDR_WIDTH(2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_write(req_write),
        .i_req_reg(req_reg),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err),
        .o_tx_udp_payload_axis_tdata(tx_tdata),
        .o_tx_udp_payload_axis_tvalid(tx_tvalid),
        .o_tx_udp_payload_axis_tlast(tx_tlast),
        .i_tx_udp_payload_axis_tready(tx_tready),
        .i_rx_udp_payload_axis_tdata(rx_tdata),
        .i_rx_udp_payload_axis_tvalid(rx_tvalid),
        .i_rx_udp_payload_axis_tlast(rx_tlast),
        .o_rx_udp_payload_axis_tready(rx_tready)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned tr_mode = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation of TX handshakes, responses and protocol invariants.
    logic [7:0]  txq[$];
    logic        txlq[$];
    int unsigned tx_last_cyc = 0;
    int unsigned rsp_cnt = 0, rsp_cyc = 0;
    logic [31:0] rsp_rdata_s = '0;
    logic        rsp_err_s = 1'b0;
    int unsigned stall_viol = 0, pulse_viol = 0;
    logic        stall_q = 1'b0, prev_rsp = 1'b0, stall_last = 1'b0;
    logic [7:0]  stall_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q  <= 1'b0;
            prev_rsp <= 1'b0;
        end else begin
            if (stall_q && !(tx_tvalid && tx_tdata === stall_data && tx_tlast === stall_last))
                stall_viol <= stall_viol + 1;
            stall_q    <= tx_tvalid && !tx_tready;
            stall_data <= tx_tdata;
            stall_last <= tx_tlast;
            if (tx_tvalid && tx_tready) begin
                txq.push_back(tx_tdata);
                txlq.push_back(tx_tlast);
                if (tx_tlast) tx_last_cyc <= cyc;
            end
            prev_rsp <= rsp_valid;
            if (prev_rsp && rsp_valid) pulse_viol <= pulse_viol + 1;
            if (rsp_valid) begin
                rsp_cnt     <= rsp_cnt + 1;
                rsp_cyc     <= cyc;
                rsp_rdata_s <= rsp_rdata;
                rsp_err_s   <= rsp_err;
            end
        end
    end

    initial begin
        tx_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0:       tx_tready = 1'b1;
                1:       tx_tready = ~tx_tready;
                default: tx_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue_req(input bit wr, input logic [1:0] r, input logic [31:0] d, input string tag);
        bit got = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_reg = r; req_wdata = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin got = 1; break; end
        end
        chk({tag, "_accept_bound"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_drop"}, 32'(req_ready), 32'd0);
        chk({tag, "_first_tvalid"}, 32'(tx_tvalid), 32'd1);
        chk({tag, "_first_tdata"}, 32'(tx_tdata), 32'h3A);
    endtask

    task automatic do_txn(input bit wr, input logic [1:0] r, input logic [31:0] d,
                          input int unsigned nrx, input string tag);
        logic [7:0]  exp[$];
        logic [7:0]  rxb[$];
        logic [31:0] exp_rd;
        logic        exp_err;
        int unsigned base;
        bit          done;
        // Model: frame from the protocol rules; response from received byte count.
        exp.push_back(8'h3A);
        exp.push_back(8'h30 + 8'(r));
        exp.push_back(wr ? 8'h57 : 8'h52);
        if (wr) for (int k = 0; k < 4; k++) exp.push_back(8'((d >> (24 - 8 * k)) & 32'hFF));
        for (int k = 0; k < int'(nrx); k++) rxb.push_back(8'($urandom_range(0, 255)));
        exp_rd = '0;
        if (!wr && nrx >= 4) for (int k = 0; k < 4; k++) exp_rd = (exp_rd << 8) | 32'(rxb[k]);
        exp_err = !wr && nrx != 4;
        base = rsp_cnt;
        txq.delete(); txlq.delete();

        issue_req(wr, r, d, tag);
        done = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (txq.size() >= exp.size()) begin done = 1; break; end
        end
        chk({tag, "_tx_bound"}, 32'(done), 32'd1);
        if (!wr && nrx > 0) begin
            #1;
            for (int k = 0; k < int'(nrx); k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rx_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
                rx_tvalid = 1'b1; rx_tdata = rxb[k]; rx_tlast = (k == int'(nrx) - 1);
                done = 0;
                for (int j = 0; j < 50; j++) begin
                    @(negedge clk);
                    if (rx_tready) begin done = 1; break; end
                end
                chk({tag, "_rx_bound"}, 32'(done), 32'd1);
                @(posedge clk); #1;
            end
            rx_tvalid = 1'b0; rx_tlast = 1'b0;
        end
        done = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (rsp_cnt != base) begin done = 1; break; end
        end
        chk({tag, "_rsp_bound"}, 32'(done), 32'd1);
        repeat (2) @(negedge clk);

        chk({tag, "_tx_len"}, txq.size(), exp.size());
        for (int k = 0; k < exp.size() && k < txq.size(); k++) begin
            chk($sformatf("%s_tx_byte%0d", tag, k), 32'(txq[k]), 32'(exp[k]));
            chk($sformatf("%s_tx_last%0d", tag, k), 32'(txlq[k]), 32'(k == exp.size() - 1));
        end
        chk({tag, "_rsp_count"}, rsp_cnt, base + 1);
        chk({tag, "_rsp_err"}, 32'(rsp_err_s), 32'(exp_err));
        if (wr || nrx == 0 || nrx >= 4) chk({tag, "_rsp_rdata"}, rsp_rdata_s, exp_rd);
        if (wr) chk({tag, "_wr_latency"}, rsp_cyc, tx_last_cyc + 1);
        if (!wr && nrx == 0) chk({tag, "_timeout_latency"}, rsp_cyc, tx_last_cyc + 101);
        chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit          done;
        int unsigned base;
        bit          wr;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_reg = '0; req_wdata = '0;
        rx_tvalid = 1'b0; rx_tdata = '0; rx_tlast = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_tvalid", 32'(tx_tvalid), 32'd0);
        chk("rst_tdata", 32'(tx_tdata), 32'd0);
        chk("rst_tlast", 32'(tx_tlast), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        tr_mode = 0;
        do_txn(1'b1, 2'd2, 32'hDEADBEEF, 0, "wr2");
        chk("idle_rx_tready", 32'(rx_tready), 32'd1);
        do_txn(1'b0, 2'd1, 32'd0, 4, "rd1");
        tr_mode = 1;
        do_txn(1'b1, 2'd3, 32'hA5C3_0F81, 0, "wr_toggle");
        tr_mode = 0;
        do_txn(1'b0, 2'd0, 32'd0, 2, "rd_short");
        do_txn(1'b0, 2'd2, 32'd0, 5, "rd_long");

        // Reset while the fourth write byte is on the bus.
        txq.delete(); txlq.delete();
        base = rsp_cnt;
        issue_req(1'b1, 2'd1, 32'h0102_0304, "rst_mid");
        done = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (txq.size() >= 3) begin done = 1; break; end
        end
        chk("rst_mid_tx_bound", 32'(done), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", 32'(tx_tvalid), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid_no_rsp", rsp_cnt, base);
        do_txn(1'b0, 2'd3, 32'd0, 4, "rd_after_rst");

        for (int t = 0; t < 20; t++) begin
            tr_mode = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            do_txn(wr, 2'($urandom_range(0, 3)), $urandom,
                   wr ? 0 : $urandom_range(1, 7), $sformatf("rand%0d", t));
        end

`ifdef RSP_TIMEOUT_EN
        tr_mode = 0;
        do_txn(1'b0, 2'd1, 32'd0, 0, "rd_timeout");
`endif

        chk("tx_stall_stable", stall_viol, 32'd0);
        chk("rsp_single_pulse", pulse_viol, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
